// File: rtl/multich_peak_detect_pkg.sv
// Shared types for the multi-channel FFT peak detector: FSM states, sample layout,
// magnitude width helper and the saturating absolute value used per channel.
package peak_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } sample_t;

    localparam int CH_MAG_W = 17;

    function automatic int mag_w(input int nch);
        return CH_MAG_W + $clog2(nch);
    endfunction

    // -32768 has no positive twin in 16 bits, so it clamps to 32767
    function automatic logic [15:0] abs_sat(input logic signed [15:0] v);
        logic [15:0] r;
        if (v == 16'sh8000) begin
            r = 16'h7fff;
        end else if (v[15]) begin
            r = 16'(-v);
        end else begin
            r = 16'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/multich_peak_detect_if.sv
// Bus between the peak detector and its environment (FFT RAMs, control, results).
// Optional second-peak results appear when SECOND_PEAK_EN is defined.
interface multich_peak_detect_if #(
    parameter int NCH   = 4,
    parameter int BIN_W = 10
);
    localparam int MAG_W = peak_pkg::mag_w(NCH);

    logic                  fftdone;
    logic [MAG_W-1:0]      thresh;
    logic [NCH-1:0][31:0]  ramq;
    logic [BIN_W-1:0]      ramaddr;
    logic                  busy;
    logic                  detectdone;
    logic [BIN_W-1:0]      maxbin;
    logic [MAG_W-1:0]      maxmag;
    logic                  valid;
    logic                  overrun;
`ifdef SECOND_PEAK_EN
    logic [BIN_W-1:0]      secbin;
    logic [MAG_W-1:0]      secmag;

    modport master (output fftdone, thresh, ramq,
                    input  ramaddr, busy, detectdone, maxbin, maxmag, valid, overrun,
                           secbin, secmag);
    modport slave  (input  fftdone, thresh, ramq,
                    output ramaddr, busy, detectdone, maxbin, maxmag, valid, overrun,
                           secbin, secmag);
`else
    modport master (output fftdone, thresh, ramq,
                    input  ramaddr, busy, detectdone, maxbin, maxmag, valid, overrun);
    modport slave  (input  fftdone, thresh, ramq,
                    output ramaddr, busy, detectdone, maxbin, maxmag, valid, overrun);
`endif

endinterface

// File: rtl/multich_peak_detect_cplx_mag_abs.sv
// L1 magnitude |re| + |im| of one complex sample, each component saturated to 32767.
module cplx_mag_abs
    import peak_pkg::*;
(
    input  sample_t               sample_i,
    output logic [CH_MAG_W-1:0]   mag_o
);

    // Both terms fit in 15 bits, so the 17-bit sum never wraps
    always_comb begin
        mag_o = CH_MAG_W'(abs_sat(sample_i.re)) + CH_MAG_W'(abs_sat(sample_i.im));
    end

endmodule

// File: rtl/multich_peak_detect.sv
// Scans BIN_LO..BIN_HI of NCH FFT RAMs, sums per-channel magnitudes and reports the
// strongest bin. Define SECOND_PEAK_EN to also report a separated second peak.
module multich_peak_detect
    import peak_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int BIN_W   = 10,
    parameter int BIN_LO  = 1,
    parameter int BIN_HI  = 511,
    parameter int MIN_SEP = 4
) (
    input  logic                   clk,
    input  logic [3:0]             KEY,
    multich_peak_detect_if.slave   bus
);

    localparam int MAG_W = mag_w(NCH);

    logic                   rst_n_s;
    logic                   unused_key_s;
    logic [CH_MAG_W-1:0]    ch_mag_s [NCH];
    logic [MAG_W-1:0]       mag_sum_s;

    state_t                 state_q;
    logic [BIN_W-1:0]       ramaddr_q;
    logic                   issue_q;
    logic                   s1_v_q;
    logic [BIN_W-1:0]       s1_bin_q;
    logic                   s2_v_q;
    logic [BIN_W-1:0]       s2_bin_q;
    logic [MAG_W-1:0]       s2_mag_q;
    logic [MAG_W-1:0]       thresh_q;
    logic [BIN_W-1:0]       best_bin_q, best_bin_d;
    logic [MAG_W-1:0]       best_mag_q, best_mag_d;
    logic                   busy_q;
    logic                   detectdone_q;
    logic [BIN_W-1:0]       maxbin_q;
    logic [MAG_W-1:0]       maxmag_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic                   pending_q;

    assign rst_n_s      = KEY[0];
    assign unused_key_s = ^KEY[3:1];

    function automatic logic [BIN_W-1:0] bin_dist(input logic [BIN_W-1:0] a,
                                                  input logic [BIN_W-1:0] b);
        logic [BIN_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        cplx_mag_abs u_mag (
            .sample_i (sample_t'(bus.ramq[g])),
            .mag_o    (ch_mag_s[g])
        );
    end

    // Sum of all channel magnitudes for the sample currently on ramq
    always_comb begin
        mag_sum_s = {MAG_W{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            mag_sum_s = mag_sum_s + MAG_W'(ch_mag_s[c]);
        end
    end

    // Running maximum: strictly-greater replacement keeps the lowest bin on ties
    always_comb begin
        best_bin_d = best_bin_q;
        best_mag_d = best_mag_q;
        if (s2_v_q && (s2_mag_q > best_mag_q)) begin
            best_bin_d = s2_bin_q;
            best_mag_d = s2_mag_q;
        end else begin
            best_bin_d = best_bin_q;
            best_mag_d = best_mag_q;
        end
    end

`ifdef SECOND_PEAK_EN
    logic [BIN_W-1:0]       sec_bin_q, sec_bin_d;
    logic [MAG_W-1:0]       sec_mag_q, sec_mag_d;
    logic [BIN_W-1:0]       secbin_q;
    logic [MAG_W-1:0]       secmag_q;

    // Runner-up must stay MIN_SEP bins away from whichever bin is currently best
    always_comb begin
        sec_bin_d = sec_bin_q;
        sec_mag_d = sec_mag_q;
        if (!s2_v_q) begin
            sec_bin_d = sec_bin_q;
            sec_mag_d = sec_mag_q;
        end else if (s2_mag_q > best_mag_q) begin
            if ((best_mag_q != {MAG_W{1'b0}}) &&
                (bin_dist(best_bin_q, s2_bin_q) >= BIN_W'(MIN_SEP))) begin
                sec_bin_d = best_bin_q;
                sec_mag_d = best_mag_q;
            end else if ((sec_mag_q != {MAG_W{1'b0}}) &&
                         (bin_dist(sec_bin_q, s2_bin_q) >= BIN_W'(MIN_SEP))) begin
                sec_bin_d = sec_bin_q;
                sec_mag_d = sec_mag_q;
            end else begin
                sec_bin_d = {BIN_W{1'b0}};
                sec_mag_d = {MAG_W{1'b0}};
            end
        end else if ((bin_dist(s2_bin_q, best_bin_q) >= BIN_W'(MIN_SEP)) &&
                     (s2_mag_q > sec_mag_q)) begin
            sec_bin_d = s2_bin_q;
            sec_mag_d = s2_mag_q;
        end else begin
            sec_bin_d = sec_bin_q;
            sec_mag_d = sec_mag_q;
        end
    end

    // Second-peak tracking and its published copy
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sec_bin_q <= {BIN_W{1'b0}};
            sec_mag_q <= {MAG_W{1'b0}};
            secbin_q  <= {BIN_W{1'b0}};
            secmag_q  <= {MAG_W{1'b0}};
        end else begin
            sec_bin_q <= sec_bin_d;
            sec_mag_q <= sec_mag_d;
            if ((state_q == IDLE) && (bus.fftdone || pending_q)) begin
                sec_bin_q <= {BIN_W{1'b0}};
                sec_mag_q <= {MAG_W{1'b0}};
            end
            if (state_q == DONE) begin
                secbin_q <= sec_bin_q;
                secmag_q <= sec_mag_q;
            end
        end
    end

    assign bus.secbin = secbin_q;
    assign bus.secmag = secmag_q;
`endif

    // Scan control FSM, read pipeline, best tracking and registered results
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q      <= IDLE;
            ramaddr_q    <= {BIN_W{1'b0}};
            issue_q      <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_bin_q     <= {BIN_W{1'b0}};
            s2_v_q       <= 1'b0;
            s2_bin_q     <= {BIN_W{1'b0}};
            s2_mag_q     <= {MAG_W{1'b0}};
            thresh_q     <= {MAG_W{1'b0}};
            best_bin_q   <= {BIN_W{1'b0}};
            best_mag_q   <= {MAG_W{1'b0}};
            busy_q       <= 1'b0;
            detectdone_q <= 1'b0;
            maxbin_q     <= {BIN_W{1'b0}};
            maxmag_q     <= {MAG_W{1'b0}};
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            s1_v_q       <= issue_q;
            s1_bin_q     <= ramaddr_q;
            s2_v_q       <= s1_v_q;
            s2_bin_q     <= s1_bin_q;
            s2_mag_q     <= mag_sum_s;
            best_bin_q   <= best_bin_d;
            best_mag_q   <= best_mag_d;
            detectdone_q <= 1'b0;
            if ((state_q != IDLE) && bus.fftdone) begin
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    pending_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    issue_q <= 1'b0;
                    if (bus.fftdone || pending_q) begin
                        ramaddr_q  <= BIN_W'(BIN_LO);
                        issue_q    <= 1'b1;
                        thresh_q   <= bus.thresh;
                        best_bin_q <= BIN_W'(BIN_LO);
                        best_mag_q <= {MAG_W{1'b0}};
                        busy_q     <= 1'b1;
                        pending_q  <= pending_q & bus.fftdone;
                        state_q    <= SCAN;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                SCAN: begin
                    if (ramaddr_q == BIN_W'(BIN_HI)) begin
                        issue_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        ramaddr_q <= ramaddr_q + BIN_W'(1);
                        state_q   <= SCAN;
                    end
                end
                DRAIN: begin
                    if (s2_v_q && (s2_bin_q == BIN_W'(BIN_HI))) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DONE: begin
                    detectdone_q <= 1'b1;
                    maxbin_q     <= best_bin_q;
                    maxmag_q     <= best_mag_q;
                    valid_q      <= (best_mag_q >= thresh_q);
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    issue_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ramaddr    = ramaddr_q;
    assign bus.busy       = busy_q;
    assign bus.detectdone = detectdone_q;
    assign bus.maxbin     = maxbin_q;
    assign bus.maxmag     = maxmag_q;
    assign bus.valid      = valid_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_multich_peak_detect.sv
// Directed bench for multich_peak_detect: RAM model, scoreboard of expected results
// and latencies, reset/tie/saturation/pending/overrun/mid-scan-reset scenarios.
module tb_multich_peak_detect;
    import peak_pkg::*;

    localparam int NCH    = 4;
    localparam int BIN_W  = 10;
    localparam int BIN_LO = 1;
    localparam int BIN_HI = 511;
    localparam int LAT    = BIN_HI - BIN_LO + 1 + 3;

    typedef struct {
        int   at_edge;
        int   bin;
        int   mag;
        int   vld;
        int   sbin;
        int   smag;
    } exp_t;

    logic        clk = 1'b0;
    logic [3:0]  key;
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_done = 0;
    exp_t        sb[$];
    logic [31:0] mem [NCH][1024];

    always #5 clk = ~clk;

    multich_peak_detect_if #(.NCH(NCH), .BIN_W(BIN_W)) bus();

    multich_peak_detect #(
        .NCH(NCH), .BIN_W(BIN_W), .BIN_LO(BIN_LO), .BIN_HI(BIN_HI), .MIN_SEP(4)
    ) dut (
        .clk (clk),
        .KEY (key),
        .bus (bus)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) bus.ramq[c] <= mem[c][bus.ramaddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int tb_abs(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    task automatic clear_mem();
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < 1024; b++) mem[c][b] = 32'h0;
    endtask

    task automatic set_ch(input int c, input int b, input int re, input int im);
        mem[c][b] = {16'(re), 16'(im)};
    endtask

    task automatic set_all(input int b, input int re, input int im);
        for (int c = 0; c < NCH; c++) set_ch(c, b, re, im);
    endtask

    task automatic push_expect(input int at, input int sbin, input int smag);
        exp_t e;
        int best, bb, s;
        logic signed [15:0] r, i;
        best = 0;
        bb   = BIN_LO;
        for (int b = BIN_LO; b <= BIN_HI; b++) begin
            s = 0;
            for (int c = 0; c < NCH; c++) begin
                r = mem[c][b][31:16];
                i = mem[c][b][15:0];
                s += tb_abs(int'(r)) + tb_abs(int'(i));
            end
            if (s > best) begin
                best = s;
                bb   = b;
            end
        end
        e.at_edge = at;
        e.bin     = bb;
        e.mag     = best;
        e.vld     = (best >= int'(bus.thresh)) ? 1 : 0;
        e.sbin    = sbin;
        e.smag    = smag;
        sb.push_back(e);
    endtask

    task automatic start_scan(input int sbin, input int smag, output int s);
        @(negedge clk);
        bus.fftdone = 1'b1;
        s = edge_n + 1;
        push_expect(s + LAT, sbin, smag);
        @(negedge clk);
        bus.fftdone = 1'b0;
    endtask

    task automatic fft_at(input int e);
        while (edge_n < e - 1) @(negedge clk);
        bus.fftdone = 1'b1;
        @(negedge clk);
        bus.fftdone = 1'b0;
    endtask

    task automatic wait_all(input int budget);
        int n;
        n = 0;
        while (((sb.size() != 0) || bus.busy) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (key[0] && (bus.detectdone === 1'b1)) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("done_edge", 64'(edge_n), 64'(e.at_edge));
                chk("maxbin", 64'(bus.maxbin), 64'(e.bin));
                chk("maxmag", 64'(bus.maxmag), 64'(e.mag));
                chk("valid", 64'(bus.valid), 64'(e.vld));
`ifdef SECOND_PEAK_EN
                chk("secbin", 64'(bus.secbin), 64'(e.sbin));
                chk("secmag", 64'(bus.secmag), 64'(e.smag));
`endif
            end
        end
    end

    initial begin
        int s, n0;
        bus.fftdone = 1'b0;
        bus.thresh  = '0;
        clear_mem();
        key = 4'b1111;
        #2 key = 4'b1110;
        repeat (3) @(negedge clk);
        chk("rst_ramaddr", 64'(bus.ramaddr), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_detectdone", 64'(bus.detectdone), 64'd0);
        chk("rst_maxbin", 64'(bus.maxbin), 64'd0);
        chk("rst_maxmag", 64'(bus.maxmag), 64'd0);
        chk("rst_valid", 64'(bus.valid), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        key = 4'b1111;
        repeat (2) @(negedge clk);

        // single peak in all channels
        set_all(200, 1000, -1000);
        bus.thresh = 100;
        start_scan(0, 0, s);
        repeat (5) @(negedge clk);
        chk("busy_scan", 64'(bus.busy), 64'd1);
        wait_all(2000);
        chk("ramaddr_hold", 64'(bus.ramaddr), 64'(BIN_HI));
        chk("busy_idle", 64'(bus.busy), 64'd0);

        // equal peaks: lowest bin wins; threshold just above and exactly equal
        clear_mem();
        set_all(50, 500, 500);
        set_all(300, 500, -500);
        bus.thresh = 4001;
        start_scan(300, 4000, s);
        wait_all(2000);
        bus.thresh = 4000;
        start_scan(300, 4000, s);
        wait_all(2000);

        // saturating -32768 components
        clear_mem();
        set_ch(0, 10, -32768, -32768);
        bus.thresh = 65534;
        start_scan(0, 0, s);
        wait_all(2000);

        // three peaks, close runner-up excluded from second place
        clear_mem();
        set_all(100, 1000, -1000);
        set_all(102, 750, 750);
        set_all(300, 625, -625);
        bus.thresh = 100;
        start_scan(300, 5000, s);
        wait_all(2000);

        // fftdone on the final busy edge becomes pending, not an overrun
        start_scan(300, 5000, s);
        fft_at(s + LAT);
        push_expect(s + 2 * LAT + 1, 300, 5000);
        wait_all(3000);
        chk("no_overrun_done_edge", 64'(bus.overrun), 64'd0);

        // one pending, one dropped
        n0 = n_done;
        start_scan(300, 5000, s);
        fft_at(s + 100);
        fft_at(s + 200);
        push_expect(s + 2 * LAT + 1, 300, 5000);
        wait_all(3000);
        chk("done_pulses", 64'(n_done - n0), 64'd2);
        chk("overrun_set", 64'(bus.overrun), 64'd1);

        // reset mid-scan abandons the scan
        start_scan(300, 5000, s);
        while (edge_n < s + 250) @(negedge clk);
        key = 4'b1110;
        #1;
        chk("mid_ramaddr", 64'(bus.ramaddr), 64'd0);
        chk("mid_busy", 64'(bus.busy), 64'd0);
        chk("mid_detectdone", 64'(bus.detectdone), 64'd0);
        chk("mid_maxbin", 64'(bus.maxbin), 64'd0);
        chk("mid_maxmag", 64'(bus.maxmag), 64'd0);
        chk("mid_valid", 64'(bus.valid), 64'd0);
        chk("mid_overrun", 64'(bus.overrun), 64'd0);
        sb.delete();
        n0 = n_done;
        repeat (3) @(negedge clk);
        key = 4'b1111;
        repeat (600) @(negedge clk);
        chk("no_done_after_rst", 64'(n_done - n0), 64'd0);
        chk("idle_after_rst", 64'(bus.busy), 64'd0);
        start_scan(300, 5000, s);
        wait_all(2000);
        chk("overrun_clear", 64'(bus.overrun), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multich_peak_detect.md
MULTICH_PEAK_DETECT -- requirements
Module: multich_peak_detect

Interface
REQ-001 Parameter NCH, default 4, number of FFT channels scanned in parallel.
REQ-002 Parameter BIN_W, default 10, bin address width.
REQ-003 Parameter BIN_LO, default 1, first bin scanned.
REQ-004 Parameter BIN_HI, default 511, last bin scanned; BIN_LO <= BIN_HI < 2**BIN_W.
REQ-005 Parameter MIN_SEP, default 4, minimum bin distance for the second peak.
REQ-006 Port clk  input  1  single clock; all state on its rising edge.
REQ-007 Port KEY  input  4  KEY[0] is the reset: asynchronous, active-low; KEY[3:1] unused.
REQ-008 Port fftdone  input  1  one-cycle pulse: FFT RAMs hold a complete frame.
REQ-009 Port thresh  input  MAG_W  detection threshold, sampled at scan start.
REQ-010 Port ramq  input  NCH x 32  per-channel RAM read data: {re[31:16], im[15:0]}, signed; 1-cycle read latency.
REQ-011 Port ramaddr  output  BIN_W  shared read address to all channel RAMs.
REQ-012 Port busy  output  1  scan in progress.
REQ-013 Port detectdone  output  1  one-cycle pulse: results updated.
REQ-014 Port maxbin  output  BIN_W  bin with largest summed magnitude.
REQ-015 Port maxmag  output  MAG_W  summed magnitude at maxbin; MAG_W = 17 + clog2(NCH).
REQ-016 Port valid  output  1  maxmag >= thresh.
REQ-017 Port overrun  output  1  sticky: an fftdone was dropped.

Function
REQ-018 Per-channel magnitude SHALL be |re| + |im|, each abs saturated (-32768 -> 32767); channel magnitudes are summed at full MAG_W width without overflow.
REQ-019 FSM states SHALL be IDLE, SCAN, DRAIN, DONE.
REQ-020 IDLE with fftdone=1: ramaddr <= BIN_LO, thresh latched, best registers cleared, state -> SCAN.
REQ-021 SCAN: ramaddr increments by 1 per cycle; after issuing BIN_HI, state -> DRAIN.
REQ-022 Pipeline: address at edge t, ramq valid at t+1, summed magnitude registered at t+2, compared at t+3.
REQ-023 DRAIN SHALL last until the BIN_HI comparison completes, then DONE.
REQ-024 DONE: detectdone=1 for exactly one cycle; maxbin, maxmag, valid update on the same edge; state -> IDLE.
REQ-025 detectdone SHALL assert exactly (BIN_HI-BIN_LO+1)+3 cycles after the edge that sampled fftdone.
REQ-026 A candidate replaces the best only if strictly greater; ties keep the lowest bin.
REQ-027 maxbin/maxmag/valid SHALL hold between detectdone pulses; busy=1 in SCAN, DRAIN, DONE.
REQ-028 fftdone while busy SHALL set a one-deep pending flag; the pending scan starts on the cycle after DONE without a new fftdone.
REQ-029 fftdone while busy with pending already set SHALL be dropped and set overrun.
REQ-030 fftdone on the same edge as DONE SHALL be treated as pending, not dropped.
REQ-031 ramaddr SHALL hold its last value in IDLE.

Reset
REQ-032 KEY[0]=0 SHALL asynchronously force IDLE; ramaddr, maxbin, maxmag, valid, detectdone, busy, overrun, pending all 0.
REQ-033 Reset mid-scan SHALL abandon the scan with no detectdone; the first fftdone after release starts a fresh scan.

Configuration
REQ-034 Macro SECOND_PEAK_EN defined: adds outputs secbin (BIN_W) and secmag (MAG_W), the largest bin with |bin - maxbin| >= MIN_SEP, updated with detectdone; when the best peak is replaced, the old best moves to second only if it is >= MIN_SEP from the new one; both outputs 0 on reset and when no qualifying bin exists.
REQ-035 Macro undefined: no second-peak ports or logic; all other behaviour identical.

Structure
REQ-036 Package peak_pkg SHALL hold the state enum, the 32-bit sample type (re/im fields) and a function returning MAG_W from NCH.
REQ-037 Sub-module cplx_mag_abs SHALL compute the saturated |re|+|im| of one channel and is instantiated NCH times.

Verification
REQ-038 NCH=4, bin 200 = (1000,-1000) in all channels, all other bins 0, thresh=100 -> detectdone at cycle 514, maxbin=200, maxmag=8000, valid=1.
REQ-039 Bins 50 and 300 both summed 4000 -> maxbin=50 (tie rule).
REQ-040 Channel 0 bin 10 = (-32768,-32768), others 0 -> maxmag=65534, maxbin=10.
REQ-041 fftdone at cycles 0, 100, 200 -> second scan auto-starts after the first detectdone, overrun=1, exactly two detectdone pulses.
REQ-042 KEY[0] low at cycle 250 of a scan -> all outputs 0, no detectdone; a new fftdone completes normally.
REQ-043 SECOND_PEAK_EN, peaks 8000 at bin 100, 6000 at bin 102, 5000 at bin 300 -> maxbin=100, secbin=300, secmag=5000.
